mem_arbiter: RTL and testbench

//  Single-core memory arbiter between the instruction cache, the data cache and the one-port RAM.

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the two caches and the one-port RAM.
// slave is the arbiter's view; master is the caches-plus-RAM side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] iload;
  logic          iwait;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic [DW-1:0] dload;
  logic          dwait;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic [1:0]    ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the icache and dcache onto one RAM port; dcache wins unless
// the data streak has reached MAX_DSTREAK while an instruction fetch waits.
//
// state  | meaning
// IDLE   | no grant; RAM strobes low; pick the next requester
// IGRANT | icache owns the RAM port until ACCESS, ERROR or a dropped request
// DGRANT | dcache owns the RAM port until ACCESS, ERROR or a dropped request
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave arbIf
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t        state, nextState;
  logic [SW-1:0] streak, nextStreak;
  logic          dReq, iDone, dDone;

  assign dReq        = arbIf.dREN | arbIf.dWEN;
  assign arbIf.iload = arbIf.ramload;
  assign arbIf.dload = arbIf.ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= nextState;
      streak <= nextStreak;
    end
  end

  always_comb begin
    nextState      = state;
    arbIf.ramREN   = 1'b0;
    arbIf.ramWEN   = 1'b0;
    arbIf.ramaddr  = '0;
    arbIf.ramstore = '0;
    arbIf.iwait    = 1'b1;
    arbIf.dwait    = 1'b1;
    iDone          = 1'b0;
    dDone          = 1'b0;
    case (state)
      IDLE: begin
        if (dReq && !(arbIf.iREN && streak == STREAK_MAX)) nextState = DGRANT;
        else if (arbIf.iREN)                               nextState = IGRANT;
        else                                               nextState = IDLE;
      end
      DGRANT: begin
        arbIf.ramWEN   = arbIf.dWEN;
        arbIf.ramREN   = arbIf.dREN & ~arbIf.dWEN;
        arbIf.ramaddr  = arbIf.daddr;
        arbIf.ramstore = arbIf.dstore;
        // A dropped request abandons the access even if RAM answers now.
        if (!dReq) nextState = IDLE;
        else if (arbIf.ramstate == RAM_ACCESS) begin
          arbIf.dwait = 1'b0;
          dDone       = 1'b1;
          nextState   = IDLE;
        end else if (arbIf.ramstate == RAM_ERROR) nextState = IDLE;
      end
      IGRANT: begin
        arbIf.ramREN  = arbIf.iREN;
        arbIf.ramaddr = arbIf.iaddr;
        if (!arbIf.iREN) nextState = IDLE;
        else if (arbIf.ramstate == RAM_ACCESS) begin
          arbIf.iwait = 1'b0;
          iDone       = 1'b1;
          nextState   = IDLE;
        end else if (arbIf.ramstate == RAM_ERROR) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    nextStreak = streak;
    if (!arbIf.iREN || iDone)               nextStreak = '0;
    else if (dDone && streak != STREAK_MAX) nextStreak = streak + SW'(1);
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: reset, fetch, priority, starvation
// bound, write with ERROR retry, request abort and reset mid-grant.
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic RST;
  int   nCompared = 0;
  int   nMismatched = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.MAX_DSTREAK(4), .AW(32), .DW(32)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .arbIf(bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  // Enter the next cycle; inputs set afterwards apply to that cycle.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clearInputs();
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
  endtask

  // Leaves the bench at the start of the first cycle with RST low.
  task automatic doReset();
    RST = 1'b1;
    clearInputs();
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  // From an IDLE cycle with iREN and dREN held: four data completions, ending in IDLE.
  task automatic dStreakRun(input string tag);
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.ramstate = ACCESS;
      settle();
      checkVal({tag, "_dDone"}, {31'd0, bus.dwait}, 32'd0);
      checkVal({tag, "_iHeld"}, {31'd0, bus.iwait}, 32'd1);
      cyc();
      bus.ramstate = FREE;
      settle();
      checkVal({tag, "_gap"}, {31'd0, bus.ramREN}, 32'd0);
    end
  endtask

  initial begin
    RST = 1'b1;
    clearInputs();

    // Reset held two cycles with both caches requesting
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h10; bus.iaddr = 32'h20;
    for (int k = 0; k < 2; k++) begin
      cyc();
      settle();
      checkVal("rstIwait", {31'd0, bus.iwait}, 32'd1);
      checkVal("rstDwait", {31'd0, bus.dwait}, 32'd1);
      checkVal("rstStrobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    end
    cyc();
    RST = 1'b0;
    settle();
    checkVal("rstFallIdle", {31'd0, bus.ramREN}, 32'd0);
    cyc();
    settle();
    checkVal("firstGrantD", {31'd0, bus.ramREN}, 32'd1);
    checkVal("firstGrantAddr", bus.ramaddr, 32'h10);

    // Simple fetch with two BUSY cycles
    doReset();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    settle();
    checkVal("fetchIdle", {31'd0, bus.ramREN}, 32'd0);
    cyc(); bus.ramstate = BUSY; settle();
    checkVal("fetchREN", {31'd0, bus.ramREN}, 32'd1);
    checkVal("fetchAddr", bus.ramaddr, 32'h40);
    checkVal("fetchWait1", {31'd0, bus.iwait}, 32'd1);
    cyc(); settle();
    checkVal("fetchWait2", {31'd0, bus.iwait}, 32'd1);
    cyc(); bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF; settle();
    checkVal("fetchDone", {31'd0, bus.iwait}, 32'd0);
    checkVal("fetchLoad", bus.iload, 32'hDEADBEEF);
    checkVal("fetchDwait", {31'd0, bus.dwait}, 32'd1);
    cyc(); bus.iREN = 1'b0; bus.ramstate = FREE; settle();
    checkVal("fetchAfter", {31'd0, bus.ramREN}, 32'd0);

    // Simultaneous requests: data first, one IDLE cycle, then the fetch
    doReset();
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h90;
    cyc(); bus.ramstate = ACCESS; bus.ramload = 32'hA5A5_0001; settle();
    checkVal("prioAddrD", bus.ramaddr, 32'h90);
    checkVal("prioDdone", {31'd0, bus.dwait}, 32'd0);
    checkVal("prioDload", bus.dload, 32'hA5A5_0001);
    checkVal("prioIwait", {31'd0, bus.iwait}, 32'd1);
    cyc(); bus.dREN = 1'b0; bus.ramstate = ACCESS; settle();
    checkVal("prioGap", {31'd0, bus.ramREN}, 32'd0);
    checkVal("prioGapIwait", {31'd0, bus.iwait}, 32'd1);
    cyc(); settle();
    checkVal("prioAddrI", bus.ramaddr, 32'h44);
    checkVal("prioIdone", {31'd0, bus.iwait}, 32'd0);
    cyc(); bus.iREN = 1'b0; bus.ramstate = FREE;

    // Starvation bound: four data completions, then the fetch is forced
    doReset();
    bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.dREN = 1'b1; bus.daddr = 32'h200;
    dStreakRun("starve");
    cyc(); bus.ramstate = ACCESS; settle();
    checkVal("starveForcedAddr", bus.ramaddr, 32'h100);
    checkVal("starveForcedI", {31'd0, bus.iwait}, 32'd0);
    checkVal("starveNoFifthD", {31'd0, bus.dwait}, 32'd1);
    cyc(); bus.ramstate = FREE; bus.iREN = 1'b0; settle();
    cyc(); settle();
    checkVal("starveClearD", bus.ramaddr, 32'h200);
    bus.dREN = 1'b0;

    // Write wins over read; ERROR forces a retry
    doReset();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678;
    cyc(); bus.ramstate = ERROR; settle();
    checkVal("wrStrobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd1);
    checkVal("wrAddr", bus.ramaddr, 32'h80);
    checkVal("wrStore", bus.ramstore, 32'h12345678);
    checkVal("wrErrWait", {31'd0, bus.dwait}, 32'd1);
    cyc(); bus.ramstate = FREE; settle();
    checkVal("wrErrIdle", {31'd0, bus.ramWEN}, 32'd0);
    cyc(); bus.ramstate = BUSY; settle();
    checkVal("wrRetry", {31'd0, bus.ramWEN}, 32'd1);
    checkVal("wrBusyWait", {31'd0, bus.dwait}, 32'd1);
    cyc(); bus.ramstate = ACCESS; settle();
    checkVal("wrDone", {31'd0, bus.dwait}, 32'd0);
    cyc(); bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;

    // Data request dropped mid-grant
    doReset();
    bus.dREN = 1'b1; bus.daddr = 32'h60;
    cyc(); bus.ramstate = BUSY; settle();
    checkVal("abortGrant", {31'd0, bus.ramREN}, 32'd1);
    cyc(); bus.dREN = 1'b0; bus.ramstate = ACCESS; settle();
    checkVal("abortStrobe", {31'd0, bus.ramREN}, 32'd0);
    checkVal("abortNoDone", {31'd0, bus.dwait}, 32'd1);
    cyc(); bus.dREN = 1'b1; settle();
    checkVal("abortIdle", {31'd0, bus.ramREN}, 32'd0);
    checkVal("abortIdleWait", {31'd0, bus.dwait}, 32'd1);

    // Reset mid-IGRANT with a saturated streak: fetch abandoned, streak cleared
    doReset();
    bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.dREN = 1'b1; bus.daddr = 32'h400;
    dStreakRun("pre");
    cyc(); bus.ramstate = BUSY; RST = 1'b1; settle();
    checkVal("rstMidAddr", bus.ramaddr, 32'h300);
    checkVal("rstMidIwait", {31'd0, bus.iwait}, 32'd1);
    cyc(); RST = 1'b0; bus.ramstate = ACCESS; settle();
    checkVal("rstMidIdle", {31'd0, bus.ramREN}, 32'd0);
    checkVal("rstMidNoDone", {31'd0, bus.iwait}, 32'd1);
    bus.ramstate = FREE;
    dStreakRun("post");
    cyc(); bus.ramstate = ACCESS; settle();
    checkVal("postForcedI", {31'd0, bus.iwait}, 32'd0);
    cyc(); clearInputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
